// File: rtl/dump_pkg.sv
// Shared types for the post-run architectural state dump.
package dump_pkg;

    localparam int unsigned DUMP_REGS  = 32;
    localparam int unsigned DUMP_W     = 64;
    // Wide enough for any register number or data-segment word address.
    localparam int unsigned DUMP_IDX_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StRegs,
        StMemReq,
        StMemWait,
        StMemSend,
        StFin
    } dump_state_t;

    typedef struct packed {
        logic [DUMP_W-1:0]     data;
        logic                  is_mem;
        logic [DUMP_IDX_W-1:0] index;
        logic                  last;
    } dump_beat_t;

    function automatic dump_beat_t make_beat(input logic [DUMP_W-1:0]     data,
                                             input logic                  is_mem,
                                             input logic [DUMP_IDX_W-1:0] index,
                                             input logic                  last);
        dump_beat_t b;
        b.data   = data;
        b.is_mem = is_mem;
        b.index  = index;
        b.last   = last;
        return b;
    endfunction

endpackage

// File: rtl/debug_dump_unit_if.sv
// Output stream and data-segment read port of the dump unit.
interface debug_dump_unit_if #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_ADDR_W = 10
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic                  out_is_mem;
    logic [MEM_ADDR_W-1:0] out_index;
    logic                  out_last;

    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_rd;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output out_valid, out_data, out_is_mem, out_index, out_last, mem_addr, mem_rd,
        input  out_ready, mem_rdata
    );

    modport slave (
        input  out_valid, out_data, out_is_mem, out_index, out_last, mem_addr, mem_rd,
        output out_ready, mem_rdata
    );
endinterface

// File: rtl/debug_dump_unit.sv
// Freezes the core on except/done, snapshots the GPRs and streams them, followed by a
// window of data-segment words, one word per valid/ready handshake.
module debug_dump_unit
    import dump_pkg::*;
#(
    parameter int unsigned NUM_REGS   = DUMP_REGS,
    parameter int unsigned DATA_W     = DUMP_W,
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned MEM_BASE   = 0,
    parameter int unsigned MEM_WORDS  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         except,
    input  logic                         done,
    input  logic [NUM_REGS*DATA_W-1:0]   debug_reg_out,
    output logic                         halt_req,
    output logic                         dump_done,
    debug_dump_unit_if.master            bus
);

    localparam int unsigned RegCntW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned MemCntW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [RegCntW-1:0]    RegLast = RegCntW'(NUM_REGS - 1);
    localparam logic [MemCntW-1:0]    MemLast = MemCntW'((MEM_WORDS > 0) ? MEM_WORDS - 1 : 0);
    localparam logic [MEM_ADDR_W-1:0] MemBase = MEM_ADDR_W'(MEM_BASE);
    localparam logic                  HasMem  = (MEM_WORDS > 0);

    dump_state_t          state_q, state_d;
    logic [RegCntW-1:0]   r_q, r_d;
    logic [MemCntW-1:0]   m_q, m_d;
    logic                 halt_q, halt_d;
    logic [DATA_W-1:0]    payload_q, payload_d;
    logic [DATA_W-1:0]    shadow_q [NUM_REGS];
    logic [MEM_ADDR_W-1:0] mem_idx;
    logic                 accept;

    // Window address wraps naturally at the top of the address space.
    assign mem_idx = MemBase + MEM_ADDR_W'(m_q);
    assign accept  = bus.out_valid & bus.out_ready;

    assign halt_req = halt_q;

    // State, counters, halt flag and memory payload with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            r_q       <= '0;
            m_q       <= '0;
            halt_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            m_q       <= m_d;
            halt_q    <= halt_d;
            payload_q <= payload_d;
        end
    end

    // Shadow copy of the GPR file, taken once the core already sees halt_req.
    always_ff @(posedge clock) begin
        if (reset && state_q == StSnap) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= debug_reg_out[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic and decoded stream/memory outputs.
    always_comb begin
        state_d        = state_q;
        r_d            = r_q;
        m_d            = m_q;
        halt_d         = halt_q;
        payload_d      = payload_q;
        dump_done      = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_is_mem = 1'b0;
        bus.out_index  = '0;
        bus.out_last   = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_addr   = '0;

        unique case (state_q)
            StIdle: begin
                if (except | done) begin
                    state_d = StSnap;
                    halt_d  = 1'b1;
                end
            end
            StSnap: begin
                r_d     = '0;
                m_d     = '0;
                state_d = StRegs;
            end
            StRegs: begin
                bus.out_valid = 1'b1;
                bus.out_data  = shadow_q[r_q];
                bus.out_index = MEM_ADDR_W'(r_q);
                bus.out_last  = !HasMem && (r_q == RegLast);
                if (accept) begin
                    if (r_q == RegLast) begin
                        state_d = HasMem ? StMemReq : StFin;
                    end else begin
                        r_d = r_q + RegCntW'(1);
                    end
                end
            end
            StMemReq: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = mem_idx;
                state_d      = StMemWait;
            end
            StMemWait: begin
                payload_d = bus.mem_rdata;
                state_d   = StMemSend;
            end
            StMemSend: begin
                bus.out_valid  = 1'b1;
                bus.out_data   = payload_q;
                bus.out_is_mem = 1'b1;
                bus.out_index  = mem_idx;
                bus.out_last   = (m_q == MemLast);
                if (accept) begin
                    if (m_q == MemLast) begin
                        state_d = StFin;
                    end else begin
                        m_d     = m_q + MemCntW'(1);
                        state_d = StMemReq;
                    end
                end
            end
            StFin: begin
                dump_done = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_unit.sv
// Scoreboard bench for debug_dump_unit: three configurations (with memory window,
// registers only, wrapping window) share one clock and reset.
module tb_debug_dump_unit;
    import dump_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic except_a, done_a, except_b, done_b, except_c, done_c;
    logic halt_a, halt_b, halt_c, dump_done_a, dump_done_b, dump_done_c;
    logic [32*64-1:0] gpr;
    logic [4*64-1:0]  gpr_c;
    logic             rnd_a;

    debug_dump_unit_if #(.DATA_W(64), .MEM_ADDR_W(10)) if_a ();
    debug_dump_unit_if #(.DATA_W(64), .MEM_ADDR_W(10)) if_b ();
    debug_dump_unit_if #(.DATA_W(64), .MEM_ADDR_W(4))  if_c ();

    debug_dump_unit #(
        .NUM_REGS(32), .DATA_W(64), .MEM_ADDR_W(10), .MEM_BASE(4), .MEM_WORDS(3)
    ) u_a (
        .clock(clk), .reset(reset), .except(except_a), .done(done_a), .debug_reg_out(gpr),
        .halt_req(halt_a), .dump_done(dump_done_a), .bus(if_a)
    );

    debug_dump_unit #(
        .NUM_REGS(32), .DATA_W(64), .MEM_ADDR_W(10), .MEM_BASE(0), .MEM_WORDS(0)
    ) u_b (
        .clock(clk), .reset(reset), .except(except_b), .done(done_b), .debug_reg_out(gpr),
        .halt_req(halt_b), .dump_done(dump_done_b), .bus(if_b)
    );

    debug_dump_unit #(
        .NUM_REGS(4), .DATA_W(64), .MEM_ADDR_W(4), .MEM_BASE(14), .MEM_WORDS(4)
    ) u_c (
        .clock(clk), .reset(reset), .except(except_c), .done(done_c), .debug_reg_out(gpr_c),
        .halt_req(halt_c), .dump_done(dump_done_c), .bus(if_c)
    );

    // Memory models: request seen at the negedge, data returned on the following posedge.
    logic [63:0] mem_a [1024];
    logic [63:0] mem_c [16];
    logic        rd_a, rd_c;
    logic [9:0]  ra_a;
    logic [3:0]  ra_c;
    assign if_b.mem_rdata = '0;

    always @(negedge clk) begin
        rd_a <= if_a.mem_rd;
        ra_a <= if_a.mem_addr;
        rd_c <= if_c.mem_rd;
        ra_c <= if_c.mem_addr;
    end

    always @(posedge clk) begin
        if (rd_a) if_a.mem_rdata <= mem_a[ra_a];
        if (rd_c) if_c.mem_rdata <= mem_c[ra_c];
    end

    dump_beat_t q_a[$], q_b[$], q_c[$];
    int         qaddr_c[$];
    dump_beat_t beat_a, beat_b, beat_c, prev_a;
    logic       stall_a;

    assign beat_a = {if_a.out_data, if_a.out_is_mem, 16'(if_a.out_index), if_a.out_last};
    assign beat_b = {if_b.out_data, if_b.out_is_mem, 16'(if_b.out_index), if_b.out_last};
    assign beat_c = {if_c.out_data, if_c.out_is_mem, 16'(if_c.out_index), if_c.out_last};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every accepted beat is popped against the scoreboard queue.
    always @(negedge clk) begin
        if (reset && if_a.out_valid && if_a.out_ready) begin
            check("a beat expected", 128'(q_a.size() != 0), 128'd1);
            if (q_a.size() != 0) begin
                check($sformatf("a beat idx %0d", q_a[0].index), 128'(beat_a), 128'(q_a[0]));
                void'(q_a.pop_front());
            end
        end
        if (reset && if_b.out_valid && if_b.out_ready) begin
            check("b beat expected", 128'(q_b.size() != 0), 128'd1);
            if (q_b.size() != 0) begin
                check($sformatf("b beat idx %0d", q_b[0].index), 128'(beat_b), 128'(q_b[0]));
                void'(q_b.pop_front());
            end
        end
        if (reset && if_c.out_valid && if_c.out_ready) begin
            check("c beat expected", 128'(q_c.size() != 0), 128'd1);
            if (q_c.size() != 0) begin
                check($sformatf("c beat idx %0d", q_c[0].index), 128'(beat_c), 128'(q_c[0]));
                void'(q_c.pop_front());
            end
        end
        if (reset && if_c.mem_rd) begin
            check("c mem_addr expected", 128'(qaddr_c.size() != 0), 128'd1);
            if (qaddr_c.size() != 0) begin
                check($sformatf("c mem_addr seq %0d", qaddr_c[0]), 128'(if_c.mem_addr),
                      128'(qaddr_c[0]));
                void'(qaddr_c.pop_front());
            end
        end
    end

    // Stall monitor: a beat held back by out_ready=0 must not change.
    always @(negedge clk) begin
        if (reset && stall_a) begin
            check("a stable while stalled", 128'({if_a.out_valid, beat_a}), 128'({1'b1, prev_a}));
        end
        stall_a <= reset && if_a.out_valid && !if_a.out_ready;
        prev_a  <= beat_a;
    end

    // Ready driver for instance a: always ready, or ready about 70% of cycles.
    initial begin
        if_a.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if_a.out_ready = rnd_a ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic push(input int w, input logic [63:0] d, input logic m, input int idx,
                        input logic l);
        dump_beat_t b;
        b = make_beat(d, m, 16'(idx), l);
        case (w)
            0:       q_a.push_back(b);
            1:       q_b.push_back(b);
            default: q_c.push_back(b);
        endcase
    endtask

    task automatic load_gpr(input logic [63:0] mul, input logic [63:0] add);
        for (int i = 0; i < 32; i++) gpr[i*64 +: 64] = 64'(i) * mul + add;
    endtask

    task automatic push_regs(input int w, input logic [63:0] mul, input logic [63:0] add,
                             input logic last_on_31);
        for (int i = 0; i < 32; i++) push(w, 64'(i) * mul + add, 1'b0, i, last_on_31 && i == 31);
    endtask

    task automatic push_mem_a();
        push(0, 64'hA, 1'b1, 4, 1'b0);
        push(0, 64'hB, 1'b1, 5, 1'b0);
        push(0, 64'hC, 1'b1, 6, 1'b1);
    endtask

    task automatic pulse(input int w, input logic ex, input logic dn);
        @(posedge clk);
        #1;
        case (w)
            0:       begin except_a = ex; done_a = dn; end
            1:       begin except_b = ex; done_b = dn; end
            default: begin except_c = ex; done_c = dn; end
        endcase
        @(posedge clk);
        #1;
        except_a = 1'b0; done_a = 1'b0;
        except_b = 1'b0; done_b = 1'b0;
        except_c = 1'b0; done_c = 1'b0;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return dump_done_a;
            1:       return dump_done_b;
            default: return dump_done_c;
        endcase
    endfunction

    task automatic wait_done(input int w, input string name);
        int n;
        n = 0;
        while (!done_of(w) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, " dump_done reached"}, 128'(done_of(w)), 128'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete(); qaddr_c.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int vcnt;
        reset    = 1'b0;
        rnd_a    = 1'b0;
        except_a = 1'b0; done_a = 1'b0;
        except_b = 1'b0; done_b = 1'b0;
        except_c = 1'b0; done_c = 1'b0;
        if_b.out_ready = 1'b1;
        if_c.out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem_a[i] = 64'hDEAD_0000 + 64'(i);
        mem_a[4] = 64'hA; mem_a[5] = 64'hB; mem_a[6] = 64'hC;
        for (int i = 0; i < 16; i++) mem_c[i] = 64'h100 + 64'(i);
        for (int i = 0; i < 4; i++) gpr_c[i*64 +: 64] = 64'h1000 + 64'(i);
        load_gpr(64'h1111, 64'h0);

        // Reset state: every output low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a reset outputs", 128'({halt_a, if_a.mem_rd, if_a.out_valid, if_a.out_last,
              dump_done_a, if_a.out_data, if_a.out_index, if_a.out_is_mem, if_a.mem_addr}), '0);
        check("b reset outputs", 128'({halt_b, if_b.mem_rd, if_b.out_valid, if_b.out_last,
              dump_done_b, if_b.out_data, if_b.out_index, if_b.out_is_mem, if_b.mem_addr}), '0);
        check("c reset outputs", 128'({halt_c, if_c.mem_rd, if_c.out_valid, if_c.out_last,
              dump_done_c, if_c.out_data, if_c.out_index, if_c.out_is_mem, if_c.mem_addr}), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Registers only, always ready: 32 beats back to back.
        push_regs(1, 64'h1111, 64'h0, 1'b1);
        pulse(1, 1'b0, 1'b1);
        check("b halt_req after trigger", 128'(halt_b), 128'd1);
        n = 0;
        while (!if_b.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b first beat valid", 128'({if_b.out_valid, if_b.out_index}), 128'({1'b1, 10'd0}));
        vcnt = 0;
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            if (if_b.out_valid) vcnt++;
            if (k == 5) check("b beat 5 data", 128'(if_b.out_data), 128'h5555);
            if (k == 30) check("b no early last", 128'({if_b.out_last, dump_done_b}), '0);
        end
        check("b one beat per cycle", 128'(vcnt), 128'd31);
        check("b last on idx 31", 128'({if_b.out_last, if_b.out_index, dump_done_b}),
              128'({1'b1, 10'd31, 1'b0}));
        @(negedge clk);
        check("b dump_done next cycle", 128'({dump_done_b, if_b.out_valid}), 128'b10);
        check("b all beats seen", 128'(q_b.size()), '0);
        pulse(1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("b no second dump", 128'({if_b.out_valid, dump_done_b, halt_b}), 128'b011);

        // Registers plus memory window 4..6.
        push_regs(0, 64'h1111, 64'h0, 1'b0);
        push_mem_a();
        pulse(0, 1'b1, 1'b0);
        wait_done(0, "a");
        check("a all beats seen", 128'(q_a.size()), '0);
        do_reset();

        // Backpressure; the register file changes right after the snapshot.
        rnd_a = 1'b1;
        load_gpr(64'h0101_0101, 64'hC0DE_0000_0000_0000);
        push_regs(0, 64'h0101_0101, 64'hC0DE_0000_0000_0000, 1'b0);
        push_mem_a();
        pulse(0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        gpr = ~gpr;
        wait_done(0, "a backpressure");
        check("a backpressure all beats seen", 128'(q_a.size()), '0);
        rnd_a = 1'b0;
        do_reset();

        // Reset while beat 12 is on the bus, then a fresh dump from r=0.
        load_gpr(64'h1111, 64'h0);
        push_regs(1, 64'h1111, 64'h0, 1'b1);
        pulse(1, 1'b0, 1'b1);
        n = 0;
        while (!if_b.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check("b beat 12 presented", 128'(if_b.out_index), 128'd12);
        reset = 1'b0;
        #1;
        q_b.delete();
        @(negedge clk);
        check("b outputs after mid reset", 128'({halt_b, if_b.mem_rd, if_b.out_valid,
              if_b.out_last, dump_done_b, if_b.out_data, if_b.out_index, if_b.out_is_mem,
              if_b.mem_addr}), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_regs(1, 64'h1111, 64'h0, 1'b1);
        pulse(1, 1'b0, 1'b1);
        wait_done(1, "b restart");
        check("b restart all beats seen", 128'(q_b.size()), '0);

        // Wrapping memory window: addresses 14,15,0,1.
        for (int i = 0; i < 4; i++) push(2, 64'h1000 + 64'(i), 1'b0, i, 1'b0);
        push(2, 64'h10E, 1'b1, 14, 1'b0);
        push(2, 64'h10F, 1'b1, 15, 1'b0);
        push(2, 64'h100, 1'b1, 0, 1'b0);
        push(2, 64'h101, 1'b1, 1, 1'b1);
        qaddr_c.push_back(14); qaddr_c.push_back(15);
        qaddr_c.push_back(0);  qaddr_c.push_back(1);
        pulse(2, 1'b0, 1'b1);
        wait_done(2, "c");
        check("c all beats seen", 128'(q_c.size()), '0);
        check("c all reads seen", 128'(qaddr_c.size()), '0);
        do_reset();

        // except and done together, and again after FIN: one dump only.
        load_gpr(64'h3, 64'h77);
        push_regs(0, 64'h3, 64'h77, 1'b0);
        push_mem_a();
        pulse(0, 1'b1, 1'b1);
        wait_done(0, "a both triggers");
        pulse(0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("a no second dump", 128'({if_a.out_valid, dump_done_a, halt_a}), 128'b011);
        check("a single dump beats seen", 128'(q_a.size()), '0);
        do_reset();
        @(negedge clk);
        check("a halt_req cleared by reset", 128'({halt_a, dump_done_a}), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_dump_unit.md
Name: debug_dump_unit

Overview:
- Hardware-side reader of the machine's architectural state after a run ends.
- Triggered by `except` or `done`, it asserts `halt_req` to freeze the core, snapshots all 32 GPRs, and then streams them out one word per handshake.
- After the registers it streams a window of data-segment words.
- Sits beside full_machine and feeds a UART/JTAG bridge or a bench scoreboard, so the dump no longer depends on simulator tasks.

Parameters:
- NUM_REGS, 32, number of GPRs to snapshot and stream.
- DATA_W, 64, register and memory word width.
- MEM_ADDR_W, 10, data-segment word-address width.
- MEM_BASE, 0, first data-segment word address dumped.
- MEM_WORDS, 16, number of memory words dumped (0 = registers only).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- except  in  1  core exception flag; level, sampled in IDLE.
- done  in  1  external end-of-run request; level, sampled in IDLE.
- debug_reg_out  in  NUM_REGS*DATA_W  flattened GPR file; reg i at [i*DATA_W +: DATA_W].
- halt_req  out  1  stall request to the core.
- mem_addr  out  MEM_ADDR_W  data-segment read address.
- mem_rd  out  1  read strobe; data is returned 1 cycle later.
- mem_rdata  in  DATA_W  read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  stream payload.
- out_is_mem  out  1  0 = register word, 1 = memory word.
- out_index  out  MEM_ADDR_W  register number or memory word address.
- out_last  out  1  marks the final word of the dump.
- dump_done  out  1  sticky; set after the last beat is accepted.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - All outputs are 0: halt_req, mem_rd, out_valid, out_last, dump_done, out_data, out_index, out_is_mem, mem_addr.
  - A reset in any state aborts the dump immediately. No partial beat is held.
- States: IDLE, SNAP, REGS, MEM_REQ, MEM_WAIT, MEM_SEND, FIN.
- IDLE:
  - If (except|done)==1, go to SNAP and set halt_req=1.
  - halt_req stays 1 until reset.
- SNAP (one cycle):
  - Copy debug_reg_out into the shadow array. The snapshot is taken the cycle after the trigger, with halt_req already visible to the core.
  - Set reg counter r=0, then go to REGS.
- REGS:
  - out_valid=1, out_data=shadow[r], out_is_mem=0, out_index=r.
  - A beat is accepted when out_valid & out_ready are both 1 at a rising edge.
  - On accept with r<NUM_REGS-1: increment r and stay in REGS. Back-to-back beats run at 1 word/cycle.
  - On accept of the last register: go to MEM_REQ if MEM_WORDS>0, otherwise go to FIN.
  - out_last=1 on the last register only when MEM_WORDS==0.
- Stream stability: while out_valid=1 and out_ready=0, out_data, out_index, out_is_mem and out_last stay constant.
- MEM_REQ (one cycle):
  - mem_rd=1, mem_addr=MEM_BASE+m, where m is the memory counter starting at 0.
  - Go to MEM_WAIT.
- MEM_WAIT:
  - Latch mem_rdata into the payload register, then go to MEM_SEND.
- MEM_SEND:
  - out_valid=1, out_is_mem=1, out_index=MEM_BASE+m.
  - out_last=1 when m==MEM_WORDS-1.
  - On accept: if more words remain, increment m and go to MEM_REQ; otherwise go to FIN.
  - Memory throughput is therefore at most 1 word per 3 cycles.
- Address arithmetic: MEM_BASE+m is taken modulo 2^MEM_ADDR_W, so the window wraps to 0 at the top of the address space.
- FIN:
  - dump_done=1 and out_valid=0.
  - Stays in FIN until reset. A further except or done has no effect.
- Simultaneous except and done count as one trigger.
- A trigger arriving while reset==0 is ignored.
- Total beats = NUM_REGS + MEM_WORDS. Each index appears exactly once and in ascending order.

Decomposition:
- Shared package `dump_pkg` holds:
  - the state enum dump_state_t;
  - the stream beat struct {data, is_mem, index, last};
  - the constants DUMP_REGS=32 and DUMP_W=64.
- Optional sub-module `dump_beat_reg`: a one-entry valid/ready output register, reused by the future UART bridge. The FSM and counters stay in the top module.

Test Plan:
- Regs i=0..31 loaded with i*0x1111, MEM_WORDS=0, `done` pulsed, out_ready tied to 1:
  - 32 consecutive beats at 1/cycle;
  - beat 5 carries 0x5555;
  - out_last appears only on index 31;
  - dump_done rises 1 cycle after that beat.
- `except` asserted with MEM_BASE=4 and MEM_WORDS=3, memory[4..6]=0xA,0xB,0xC:
  - 32 register beats, then 3 memory beats with out_is_mem=1, indices 4,5,6 and data 0xA,0xB,0xC;
  - last=1 only on index 6.
- Backpressure: out_ready toggles randomly at 30%:
  - payload stays stable while stalled;
  - no beat is dropped or duplicated;
  - the scoreboard matches the snapshot even though debug_reg_out changes after SNAP.
- Reset asserted (reset=0) in the middle of beat 12:
  - the next cycle shows all outputs 0;
  - a re-trigger restarts the dump from r=0.
- Wrap: MEM_ADDR_W=4, MEM_BASE=14, MEM_WORDS=4:
  - mem_addr sequence is 14,15,0,1.
- except and done asserted together, and again after FIN:
  - exactly one dump is produced;
  - halt_req stays 1 until reset.
